// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, fetch state encoding and instruction-length decode.
// Imported by the fetch unit and the decoder.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDO  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STO  = 4'h3;
  localparam logic [3:0] OP_PRE  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_LDM  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_CLR  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    ISSUE     = 2'd2,
    HALT      = 2'd3
  } fetch_state_t;

  // Unused opcodes 1100-1110 deliberately fall through as one-byte.
  function automatic logic is_two_byte(input logic [3:0] opcode);
    return (opcode == OP_LDO) || (opcode == OP_LDA) ||
           (opcode == OP_STO) || (opcode == OP_JMP);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, assembles one/two-byte instructions from ROM,
// resolves JMP locally and hands complete instructions downstream via valid/ready.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter bit         ISSUE_JMP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rom_addr,
  output logic       rom_read,
  output logic       rom_ena,
  input  logic [7:0] rom_data,
  output logic [7:0] ir,
  output logic [7:0] operand,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] pc,
  output logic       halted
);

  fetch_state_t state, state_next;
  logic         jmp_internal;
  logic         fetching;

  assign jmp_internal = (ir[7:4] == OP_JMP) && !ISSUE_JMP;
  assign fetching     = (state == FETCH_OP) || (state == FETCH_ARG);

  // ROM port is decoded straight from state so data returns in the fetch cycle itself.
  always_comb begin
    rom_addr = pc;
    rom_read = rst_n && fetching;
    rom_ena  = rst_n && fetching;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_OP:  state_next = is_two_byte(rom_data[7:4]) ? FETCH_ARG : ISSUE;
      FETCH_ARG: state_next = jmp_internal ? FETCH_OP : ISSUE;
      ISSUE: begin
        if (instr_ready)
          state_next = (ir[7:4] == OP_HLT) ? HALT : FETCH_OP;
      end
      HALT:      state_next = HALT;
      default:   state_next = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_OP;
      pc          <= RESET_PC;
      ir          <= 8'h00;
      operand     <= 8'h00;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        FETCH_OP: begin
          ir          <= rom_data;
          operand     <= 8'h00;
          pc          <= pc + 8'd1;
          instr_valid <= !is_two_byte(rom_data[7:4]);
        end
        FETCH_ARG: begin
          operand     <= rom_data;
          pc          <= (ir[7:4] == OP_JMP) ? rom_data : pc + 8'd1;
          instr_valid <= !jmp_internal;
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            halted      <= (ir[7:4] == OP_HLT);
          end
        end
        default: begin
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (internal JMP from 0x00, issued JMP from 0xFF)
// checked against a program-level walk of their ROM images plus directed literal checks.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [7:0] rom0 [256];
  logic [7:0] rom1 [256];

  logic [7:0] ra0, rd0, ir0, op0, pc0;
  logic       rr0, re0, v0, rdy0, h0;
  logic [7:0] ra1, rd1, ir1, op1, pc1;
  logic       rr1, re1, v1, rdy1, h1;

  assign rd0 = (rr0 && re0) ? rom0[ra0] : 8'hzz;
  assign rd1 = (rr1 && re1) ? rom1[ra1] : 8'hzz;

  fetch_unit #(.RESET_PC(8'h00), .ISSUE_JMP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rom_addr(ra0), .rom_read(rr0), .rom_ena(re0),
    .rom_data(rd0), .ir(ir0), .operand(op0), .instr_valid(v0), .instr_ready(rdy0),
    .pc(pc0), .halted(h0));

  fetch_unit #(.RESET_PC(8'hFF), .ISSUE_JMP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rom_addr(ra1), .rom_read(rr1), .rom_ena(re1),
    .rom_data(rd1), .ir(ir1), .operand(op1), .instr_valid(v1), .instr_ready(rdy1),
    .pc(pc1), .halted(h1));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-level model: walk the ROM from p to the next instruction that reaches
  // downstream, returning {opcode byte, operand byte, pc after it}.
  function automatic logic [23:0] model_step(input int which, input logic [7:0] p_in);
    logic [7:0] p, op, arg;
    logic       jmp_issued;
    p = p_in;
    op = 8'h00;
    arg = 8'h00;
    jmp_issued = (which == 1);
    for (int n = 0; n < 256; n++) begin
      op  = (which == 0) ? rom0[p] : rom1[p];
      p   = p + 8'd1;
      arg = 8'h00;
      if (op[7:4] inside {4'h1, 4'h2, 4'h3, 4'hA}) begin
        arg = (which == 0) ? rom0[p] : rom1[p];
        if (op[7:4] == 4'hA) begin
          p = arg;
          if (!jmp_issued) continue;
        end else begin
          p = p + 8'd1;
        end
      end
      break;
    end
    return {op, arg, p};
  endfunction

  logic [7:0] mpc0, mpc1;
  logic       mh0, mh1;
  int         acc7b;

  // Model bookkeeping on acceptance.
  always @(posedge clk) begin
    logic [23:0] m;
    if (!rst_n) begin
      mpc0 = 8'h00; mh0 = 1'b0;
      mpc1 = 8'hFF; mh1 = 1'b0;
    end else begin
      if (v0 && rdy0) begin
        m = model_step(0, mpc0);
        mpc0 = m[7:0];
        if (m[23:20] == 4'hF) mh0 = 1'b1;
        if (ir0 == 8'h7B) acc7b++;
      end
      if (v1 && rdy1) begin
        m = model_step(1, mpc1);
        mpc1 = m[7:0];
        if (m[23:20] == 4'hF) mh1 = 1'b1;
      end
    end
  end

  // Compare process: every cycle an instruction is presented, and halted always.
  always @(negedge clk) begin
    logic [23:0] m;
    if (rst_n) begin
      chk("m0_halted", {7'd0, h0}, {7'd0, mh0});
      chk("m1_halted", {7'd0, h1}, {7'd0, mh1});
      if (v0) begin
        m = model_step(0, mpc0);
        chk("m0_ir", ir0, m[23:16]);
        chk("m0_operand", op0, m[15:8]);
        chk("m0_pc", pc0, m[7:0]);
        chk("m0_rom_read_in_issue", {7'd0, rr0}, 8'd0);
      end
      if (v1) begin
        m = model_step(1, mpc1);
        chk("m1_ir", ir1, m[23:16]);
        chk("m1_operand", op1, m[15:8]);
        chk("m1_pc", pc1, m[7:0]);
      end
    end
  end

  // Wrap-around / issued-JMP literal checks on the second instance.
  initial begin
    int n;
    rdy1 = 1'b1;
    @(posedge rst_n);
    n = 0;
    @(negedge clk);
    while (!v1 && n < 20) begin @(negedge clk); n++; end
    chk("wrap_first_issue_seen", {7'd0, v1}, 8'd1);
    chk("wrap_ir", ir1, 8'h13);
    chk("wrap_operand", op1, 8'h82);
    chk("wrap_pc", pc1, 8'h01);
    @(negedge clk);
    n = 0;
    while (!v1 && n < 20) begin @(negedge clk); n++; end
    chk("ijmp_ir", ir1, 8'hA0);
    chk("ijmp_operand", op1, 8'h40);
    chk("ijmp_pc", pc1, 8'h40);
  end

  initial begin
    int n;
    logic [7:0] hpc;
    for (int i = 0; i < 256; i++) begin rom0[i] = 8'h00; rom1[i] = 8'h00; end
    rom0[0] = 8'h00; rom0[1] = 8'h11; rom0[2] = 8'h81; rom0[3] = 8'h7B;
    rom0[4] = 8'hC5; rom0[5] = 8'h22; rom0[6] = 8'h40; rom0[7] = 8'h85;
    rom0[8] = 8'hB1; rom0[9] = 8'hA3; rom0[10] = 8'h0F; rom0[14] = 8'hF0;
    rom0[15] = 8'hB0; rom0[16] = 8'hA0; rom0[17] = 8'h0E;
    rom1[255] = 8'h13; rom1[0] = 8'h82; rom1[1] = 8'hA0; rom1[2] = 8'h40;
    rom1[8'h40] = 8'hF0;
    acc7b = 0;
    rdy0 = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rom_read", {7'd0, rr0}, 8'd0);
    chk("rst_rom_ena", {7'd0, re0}, 8'd0);
    chk("rst_valid", {7'd0, v0}, 8'd0);
    chk("rst_pc", pc0, 8'h00);
    chk("rst_ir", ir0, 8'h00);
    chk("rst_halted", {7'd0, h0}, 8'd0);
    chk("rst_pc_wrapinst", pc1, 8'hFF);
    rst_n = 1'b1;

    @(negedge clk);
    chk("first_valid", {7'd0, v0}, 8'd1);
    chk("first_ir", ir0, 8'h00);
    chk("first_operand", op0, 8'h00);
    chk("first_pc", pc0, 8'h01);
    @(negedge clk);
    chk("first_valid_drop", {7'd0, v0}, 8'd0);
    chk("ldo_addr_op", ra0, 8'h01);
    chk("ldo_read_op", {7'd0, rr0}, 8'd1);
    @(negedge clk);
    chk("ldo_addr_arg", ra0, 8'h02);
    @(negedge clk);
    chk("ldo_valid", {7'd0, v0}, 8'd1);
    chk("ldo_ir", ir0, 8'h11);
    chk("ldo_operand", op0, 8'h81);
    chk("ldo_pc", pc0, 8'h03);

    @(negedge clk);
    rdy0 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {7'd0, v0}, 8'd1);
      chk("bp_ir", ir0, 8'h7B);
      chk("bp_operand", op0, 8'h00);
      chk("bp_rom_read", {7'd0, rr0}, 8'd0);
      chk("bp_pc", pc0, 8'h04);
      if (i < 4) @(negedge clk);
    end
    chk("bp_no_accept_yet", acc7b[7:0], 8'd0);
    rdy0 = 1'b1;

    n = 0;
    while (!(ra0 == 8'h09 && rr0) && n < 50) begin @(negedge clk); n++; end
    chk("jmp_fetch_addr", ra0, 8'h09);
    chk("bp_one_accept", acc7b[7:0], 8'd1);
    @(negedge clk);
    chk("jmp_arg_addr", ra0, 8'h0A);
    @(negedge clk);
    chk("jmp_target_addr", ra0, 8'h0F);
    chk("jmp_target_read", {7'd0, rr0}, 8'd1);
    @(negedge clk);
    chk("jmp_next_valid", {7'd0, v0}, 8'd1);
    chk("jmp_next_ir", ir0, 8'hB0);
    chk("jmp_next_pc", pc0, 8'h10);

    n = 0;
    while (!(v0 && ir0 == 8'hF0) && n < 50) begin @(negedge clk); n++; end
    chk("hlt_ir", ir0, 8'hF0);
    @(negedge clk);
    hpc = 8'h0F;
    for (int i = 0; i < 20; i++) begin
      chk("hlt_halted", {7'd0, h0}, 8'd1);
      chk("hlt_rom_ena", {7'd0, re0}, 8'd0);
      chk("hlt_valid", {7'd0, v0}, 8'd0);
      chk("hlt_pc", pc0, hpc);
      @(negedge clk);
    end

    rst_n = 1'b0;
    @(negedge clk);
    rdy0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_pre_valid", {7'd0, v0}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {7'd0, v0}, 8'd0);
    chk("midrst_pc", pc0, 8'h00);
    chk("midrst_rom_read", {7'd0, rr0}, 8'd0);
    chk("midrst_halted", {7'd0, h0}, 8'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decoder/ALU and drives the program ROM's addr/read/ena port.
- Holds the program counter, reads one- and two-byte instructions from the ROM, and resolves JMP internally.
- Presents complete instructions (opcode byte plus optional operand byte) downstream with a valid/ready handshake, and stops fetching after HLT.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- ISSUE_JMP, 0, when 1 JMP is also issued downstream (trace/debug); when 0 JMP is consumed internally.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rom_addr  output  8  ROM address; equals pc in fetch states.
- rom_read  output  1  ROM read strobe.
- rom_ena  output  1  ROM enable.
- rom_data  input  8  ROM data; combinational, valid in the same cycle as addr/read/ena; 8'hzz when not read.
- ir  output  8  opcode byte of the issued instruction; [7:4] opcode, [3:0] register/immediate field.
- operand  output  8  second byte of two-byte instructions; 8'h00 for one-byte instructions.
- instr_valid  output  1  ir/operand hold an instruction for downstream.
- instr_ready  input  1  downstream accepts the instruction this cycle.
- pc  output  8  current program counter.
- halted  output  1  HLT has been issued; fetching stopped.

Behaviour:
- Opcodes decided: 0000 NOP, 0001 LDO, 0010 LDA, 0011 STO, 0100 PRE, 0101 ADD, 0110 LDM, 0111 ADDI, 1000 INC, 1001 DEC, 1010 JMP, 1011 CLR, 1111 HLT.
- Two-byte instructions: LDO, LDA, STO, JMP. All other opcodes, including unused 1100-1110, are one-byte and are issued unchanged.
- Reset (asynchronous, any state): state=FETCH_OP, pc=RESET_PC, ir=0, operand=0, instr_valid=0, halted=0. rom_read and rom_ena are 0 while rst_n=0.
- FETCH_OP:
  - rom_addr=pc, rom_read=rom_ena=1.
  - At the clock edge: ir<=rom_data, operand<=0, pc<=pc+1.
  - Next state is FETCH_ARG if the opcode is two-byte, else ISSUE.
- FETCH_ARG:
  - rom_addr=pc, rom_read=rom_ena=1.
  - At the clock edge: operand<=rom_data.
  - If ir is JMP and ISSUE_JMP=0: pc<=rom_data and next state is FETCH_OP; nothing is issued.
  - Otherwise: pc<=pc+1 (JMP with ISSUE_JMP=1 loads pc<=rom_data instead) and next state is ISSUE.
- ISSUE:
  - rom_read=rom_ena=0 and instr_valid=1.
  - ir and operand stay stable until the handshake.
  - On instr_ready=1: if ir is HLT, next state is HALT; otherwise next state is FETCH_OP.
  - instr_valid drops in the cycle after acceptance.
  - instr_ready while instr_valid=0 is ignored.
- HALT: halted=1, instr_valid=0, no ROM access, pc frozen. Only reset exits this state.
- Latency and throughput:
  - One-byte instruction: valid 1 cycle after FETCH_OP, minimum 2 cycles per instruction.
  - Two-byte instruction: 3 cycles.
  - JMP (ISSUE_JMP=0): 2 cycles, no issue.
- PC arithmetic is 8-bit modulo 256: 8'hFF+1 wraps to 8'h00, including an operand fetch across the wrap.
- Outputs are registered except rom_addr/rom_read/rom_ena, which decode from state and pc.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_NOP .. OP_HLT);
  - fetch state enum (FETCH_OP, FETCH_ARG, ISSUE, HALT);
  - function is_two_byte(opcode).
- The decoder also uses cpu_pkg.
- No sub-module; the ROM is instantiated alongside, not inside.

Test Plan:
- Reset with ROM[0]=8'h00 and instr_ready=1: first issue has ir=8'h00, operand=8'h00, pc=1; instr_valid is high 1 cycle after reset release and drops the next cycle.
- Two-byte LDO: ROM[1]=8'h11, ROM[2]=8'h81 -> issued ir=8'h11, operand=8'h81; pc=3 at issue; rom_addr sequence 1, 2.
- JMP with ISSUE_JMP=0: ROM[9]=8'hA3, ROM[10]=8'h0F, ROM[15]=8'hB0 -> no issue for the JMP; next issued ir=8'hB0 with rom_addr=15, two cycles after the JMP opcode fetch.
- Backpressure: hold instr_ready=0 for 5 cycles during ISSUE of ir=8'h7B -> ir/operand stable, rom_read=0, pc unchanged; exactly one acceptance when ready rises.
- HLT: ROM[14]=8'hF0 -> ir=8'hF0 issued; after acceptance halted=1, rom_ena=0, and no further instr_valid for 20 cycles. Assert rst_n=0 mid-ISSUE -> immediate instr_valid=0 and pc=RESET_PC.
- Wrap-around: RESET_PC=8'hFF, ROM[255]=8'h13, ROM[0]=8'h82 -> issued ir=8'h13, operand=8'h82, pc=8'h01.
